// File: rtl/bp_update_scheduler.sv
// rtl/bp_update_scheduler.sv - branch predictor update scheduler: table clear sweep, tag/BHT request queues, one table write per cycle (optional BP_TAG_COALESCE_EN)
module bp_update_scheduler #(
    parameter int WORD_SIZE    = 16,
    parameter int BTB_IDX_SIZE = 8,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              flush_req,
    input  logic                              tag_valid,
    input  logic [WORD_SIZE-1:0]              tag_pc,
    input  logic [WORD_SIZE-1:0]              tag_target,
    output logic                              tag_ready,
    input  logic                              bht_valid,
    input  logic [WORD_SIZE-1:0]              bht_pc,
    input  logic                              bht_taken,
    output logic                              bht_ready,
    output logic                              tbl_clr,
    output logic                              tbl_tag_we,
    output logic                              tbl_bht_we,
    output logic [BTB_IDX_SIZE-1:0]           tbl_idx,
    output logic [WORD_SIZE-BTB_IDX_SIZE-1:0] tbl_tag,
    output logic [WORD_SIZE-1:0]              tbl_target,
    output logic                              tbl_taken,
    output logic                              busy
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [BTB_IDX_SIZE-1:0] LAST_IDX = '1;
    localparam logic [BTB_IDX_SIZE-1:0] IDX_ONE  = BTB_IDX_SIZE'(1);
    localparam logic [PTR_W-1:0]        PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]        FULL_CNT = CNT_W'(QUEUE_DEPTH);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                  state;
    logic [BTB_IDX_SIZE-1:0] sweep_idx;
    logic                    last_bht;

    logic [WORD_SIZE-1:0] tq_pc  [QUEUE_DEPTH];
    logic [WORD_SIZE-1:0] tq_tgt [QUEUE_DEPTH];
    logic [PTR_W-1:0]     tq_rd, tq_wr;
    logic [CNT_W-1:0]     tq_cnt;

    logic [WORD_SIZE-1:0] bq_pc    [QUEUE_DEPTH];
    logic                 bq_taken [QUEUE_DEPTH];
    logic [PTR_W-1:0]     bq_rd, bq_wr;
    logic [CNT_W-1:0]     bq_cnt;

    logic             run_ok;
    logic             grant_tag, grant_bht;
    logic             tag_acc, bht_acc;
    logic             tag_coal, tag_push, bht_push;
    logic [CNT_W-1:0] tq_cnt_nxt, bq_cnt_nxt;
`ifdef BP_TAG_COALESCE_EN
    logic [PTR_W-1:0] tq_newest;
`endif

    // Arbitration, acceptance and next-occupancy; flush suppresses both issue and acceptance
    always_comb begin
        run_ok    = (state == ST_RUN) && !flush_req;
        grant_tag = run_ok && (tq_cnt != '0) && ((bq_cnt == '0) || last_bht);
        grant_bht = run_ok && (bq_cnt != '0) && ((tq_cnt == '0) || !last_bht);
        tag_acc   = tag_valid && tag_ready && !flush_req;
        bht_acc   = bht_valid && bht_ready && !flush_req;
`ifdef BP_TAG_COALESCE_EN
        tq_newest = tq_wr - PTR_ONE;
        // Merging into an entry that is leaving this very cycle would lose the new target, so push instead
        tag_coal  = tag_acc && (tq_cnt != '0) && (tq_pc[tq_newest] == tag_pc)
                    && !(grant_tag && (tq_cnt == CNT_W'(1)));
`else
        tag_coal  = 1'b0;
`endif
        tag_push   = tag_acc && !tag_coal;
        bht_push   = bht_acc;
        tq_cnt_nxt = tq_cnt + CNT_W'(tag_push) - CNT_W'(grant_tag);
        bq_cnt_nxt = bq_cnt + CNT_W'(bht_push) - CNT_W'(grant_bht);
    end

    // Queue storage writes (contents need no reset; pointers and counts define validity)
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tq_pc[tq_wr]  <= tag_pc;
            tq_tgt[tq_wr] <= tag_target;
        end
`ifdef BP_TAG_COALESCE_EN
        if (tag_coal) begin
            tq_tgt[tq_newest] <= tag_target;
        end
`endif
        if (bht_push) begin
            bq_pc[bq_wr]    <= bht_pc;
            bq_taken[bq_wr] <= bht_taken;
        end
    end

    // Control FSM: clear sweep, queue pointers, registered ready/busy and table write outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_CLEAR;
            sweep_idx  <= '0;
            last_bht   <= 1'b1;
            tq_rd      <= '0;
            tq_wr      <= '0;
            tq_cnt     <= '0;
            bq_rd      <= '0;
            bq_wr      <= '0;
            bq_cnt     <= '0;
            tag_ready  <= 1'b0;
            bht_ready  <= 1'b0;
            busy       <= 1'b1;
            tbl_clr    <= 1'b0;
            tbl_tag_we <= 1'b0;
            tbl_bht_we <= 1'b0;
            tbl_idx    <= '0;
            tbl_tag    <= '0;
            tbl_target <= '0;
            tbl_taken  <= 1'b0;
        end else begin
            tbl_clr    <= 1'b0;
            tbl_tag_we <= 1'b0;
            tbl_bht_we <= 1'b0;
            tbl_idx    <= '0;
            tbl_tag    <= '0;
            tbl_target <= '0;
            tbl_taken  <= 1'b0;
            if (flush_req) begin
                state     <= ST_CLEAR;
                sweep_idx <= '0;
                tq_rd     <= '0;
                tq_wr     <= '0;
                tq_cnt    <= '0;
                bq_rd     <= '0;
                bq_wr     <= '0;
                bq_cnt    <= '0;
                tag_ready <= 1'b0;
                bht_ready <= 1'b0;
                busy      <= 1'b1;
            end else if (state == ST_CLEAR) begin
                tbl_clr   <= 1'b1;
                tbl_idx   <= sweep_idx;
                sweep_idx <= sweep_idx + IDX_ONE;
                tag_ready <= 1'b0;
                bht_ready <= 1'b0;
                busy      <= 1'b1;
                if (sweep_idx == LAST_IDX) begin
                    state <= ST_RUN;
                end
            end else begin
                busy      <= 1'b0;
                tag_ready <= (tq_cnt_nxt < FULL_CNT);
                bht_ready <= (bq_cnt_nxt < FULL_CNT);
                tq_cnt    <= tq_cnt_nxt;
                bq_cnt    <= bq_cnt_nxt;
                if (tag_push) tq_wr <= tq_wr + PTR_ONE;
                if (bht_push) bq_wr <= bq_wr + PTR_ONE;
                if (grant_tag) begin
                    tq_rd      <= tq_rd + PTR_ONE;
                    last_bht   <= 1'b0;
                    tbl_tag_we <= 1'b1;
                    tbl_idx    <= tq_pc[tq_rd][BTB_IDX_SIZE-1:0];
                    tbl_tag    <= tq_pc[tq_rd][WORD_SIZE-1:BTB_IDX_SIZE];
                    tbl_target <= tq_tgt[tq_rd];
                end else if (grant_bht) begin
                    bq_rd      <= bq_rd + PTR_ONE;
                    last_bht   <= 1'b1;
                    tbl_bht_we <= 1'b1;
                    tbl_idx    <= bq_pc[bq_rd][BTB_IDX_SIZE-1:0];
                    tbl_tag    <= bq_pc[bq_rd][WORD_SIZE-1:BTB_IDX_SIZE];
                    tbl_taken  <= bq_taken[bq_rd];
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb/tb_bp_update_scheduler.sv - directed self-checking bench for bp_update_scheduler
module tb_bp_update_scheduler;

    logic        clk;
    logic        reset_n;
    logic        flush_req;
    logic        tag_valid;
    logic [15:0] tag_pc;
    logic [15:0] tag_target;
    logic        tag_ready;
    logic        bht_valid;
    logic [15:0] bht_pc;
    logic        bht_taken;
    logic        bht_ready;
    logic        tbl_clr;
    logic        tbl_tag_we;
    logic        tbl_bht_we;
    logic [7:0]  tbl_idx;
    logic [7:0]  tbl_tag;
    logic [15:0] tbl_target;
    logic        tbl_taken;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int onehot_err = 0;
    int bht_low_at;

    int          log_kind  [$];
    logic [15:0] log_pc    [$];
    logic [15:0] log_tgt   [$];
    logic        log_taken [$];
    int          log_cyc   [$];

    logic [15:0] s_tpc  [$];
    logic [15:0] s_ttgt [$];
    logic [15:0] s_bpc  [$];
    logic        s_btk  [$];

    bp_update_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush_req  (flush_req),
        .tag_valid  (tag_valid),
        .tag_pc     (tag_pc),
        .tag_target (tag_target),
        .tag_ready  (tag_ready),
        .bht_valid  (bht_valid),
        .bht_pc     (bht_pc),
        .bht_taken  (bht_taken),
        .bht_ready  (bht_ready),
        .tbl_clr    (tbl_clr),
        .tbl_tag_we (tbl_tag_we),
        .tbl_bht_we (tbl_bht_we),
        .tbl_idx    (tbl_idx),
        .tbl_tag    (tbl_tag),
        .tbl_target (tbl_target),
        .tbl_taken  (tbl_taken),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every table write and any cycle with more than one write strobe
    always @(negedge clk) begin
        if (reset_n) begin
            if (int'(tbl_clr) + int'(tbl_tag_we) + int'(tbl_bht_we) > 1) onehot_err++;
            if (tbl_tag_we || tbl_bht_we) begin
                log_kind.push_back(tbl_tag_we ? 1 : 2);
                log_pc.push_back({tbl_tag, tbl_idx});
                log_tgt.push_back(tbl_target);
                log_taken.push_back(tbl_taken);
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic wait_writes(input int target);
        int g = 0;
        while (log_kind.size() < target && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic drive_streams();
        int ti = 0;
        int bi = 0;
        int guard = 0;
        bht_low_at = -1;
        while ((ti < s_tpc.size() || bi < s_bpc.size()) && guard < 300) begin
            @(negedge clk);
            guard++;
            if (!bht_ready && bht_low_at < 0 && bi > 0) bht_low_at = bi;
            if (ti < s_tpc.size()) begin
                tag_valid = 1'b1; tag_pc = s_tpc[ti]; tag_target = s_ttgt[ti];
                if (tag_ready) ti++;
            end else tag_valid = 1'b0;
            if (bi < s_bpc.size()) begin
                bht_valid = 1'b1; bht_pc = s_bpc[bi]; bht_taken = s_btk[bi];
                if (bht_ready) bi++;
            end else bht_valid = 1'b0;
        end
        @(negedge clk);
        tag_valid = 1'b0;
        bht_valid = 1'b0;
        checks++;
        if (guard >= 300) begin
            errors++;
            $display("FAIL stream_timeout got tag=%0d bht=%0d accepted", ti, bi);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush_req = 0; tag_valid = 0; bht_valid = 0;
        tag_pc = 0; tag_target = 0; bht_pc = 0; bht_taken = 0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++; if (tag_ready !== 1'b0 || bht_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", tag_ready, bht_ready); end
        checks++; if ({tbl_clr, tbl_tag_we, tbl_bht_we} !== 3'b000) begin errors++; $display("FAIL reset_we got=%b exp=000", {tbl_clr, tbl_tag_we, tbl_bht_we}); end
        checks++; if (tbl_idx !== 8'h00 || tbl_target !== 16'h0000) begin errors++; $display("FAIL reset_data got idx=%h tgt=%h exp 0", tbl_idx, tbl_target); end
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            checks++;
            if (tbl_clr !== 1'b1 || tbl_idx !== 8'(i) || busy !== 1'b1) begin
                errors++;
                $display("FAIL sweep got clr=%b idx=%h busy=%b exp clr=1 idx=%h busy=1", tbl_clr, tbl_idx, busy, 8'(i));
            end
        end
        @(negedge clk);
        checks++; if (tbl_clr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sweep_end got clr=%b busy=%b exp 0 0", tbl_clr, busy); end
        checks++; if (tag_ready !== 1'b1 || bht_ready !== 1'b1) begin errors++; $display("FAIL run_ready got=%b%b exp=11", tag_ready, bht_ready); end
    endtask

    task automatic test_single_tag();
        tag_valid = 1'b1; tag_pc = 16'h1234; tag_target = 16'h1300;
        @(negedge clk);
        tag_valid = 1'b0;
        checks++; if (tbl_tag_we !== 1'b0) begin errors++; $display("FAIL tag_early got=%b exp=0", tbl_tag_we); end
        @(negedge clk);
        checks++; if (tbl_tag_we !== 1'b1 || tbl_bht_we !== 1'b0) begin errors++; $display("FAIL tag_we got=%b%b exp=10", tbl_tag_we, tbl_bht_we); end
        checks++; if (tbl_idx !== 8'h34 || tbl_tag !== 8'h12) begin errors++; $display("FAIL tag_addr got idx=%h tag=%h exp 34 12", tbl_idx, tbl_tag); end
        checks++; if (tbl_target !== 16'h1300) begin errors++; $display("FAIL tag_target got=%h exp=1300", tbl_target); end
        @(negedge clk);
        checks++; if (tbl_tag_we !== 1'b0 || tbl_target !== 16'h0000) begin errors++; $display("FAIL tag_once got we=%b tgt=%h exp 0 0", tbl_tag_we, tbl_target); end
    endtask

    task automatic test_single_bht();
        bht_valid = 1'b1; bht_pc = 16'h00A5; bht_taken = 1'b1;
        @(negedge clk);
        bht_valid = 1'b0;
        @(negedge clk);
        checks++; if (tbl_bht_we !== 1'b1 || tbl_tag_we !== 1'b0) begin errors++; $display("FAIL bht_we got=%b%b exp=01", tbl_tag_we, tbl_bht_we); end
        checks++; if (tbl_idx !== 8'hA5 || tbl_taken !== 1'b1) begin errors++; $display("FAIL bht_data got idx=%h tk=%b exp a5 1", tbl_idx, tbl_taken); end
        @(negedge clk);
        checks++; if (tbl_bht_we !== 1'b0 || tbl_taken !== 1'b0) begin errors++; $display("FAIL bht_once got we=%b tk=%b exp 0 0", tbl_bht_we, tbl_taken); end
    endtask

    task automatic test_alternate();
        int base;
        int          exp_kind [6] = '{1, 2, 1, 2, 1, 2};
        logic [15:0] exp_pc   [6] = '{16'h0101, 16'h0A11, 16'h0202, 16'h0A22, 16'h0303, 16'h0A33};
        base = log_kind.size();
        s_tpc = '{16'h0101, 16'h0202, 16'h0303}; s_ttgt = '{16'h1111, 16'h2222, 16'h3333};
        s_bpc = '{16'h0A11, 16'h0A22, 16'h0A33}; s_btk = '{1'b1, 1'b0, 1'b1};
        drive_streams();
        wait_writes(base + 6);
        checks++; if (log_kind.size() != base + 6) begin errors++; $display("FAIL alt_count got=%0d exp=%0d", log_kind.size() - base, 6); end
        else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (log_kind[base+i] != exp_kind[i] || log_pc[base+i] !== exp_pc[i]) begin
                    errors++;
                    $display("FAIL alt_order[%0d] got kind=%0d pc=%h exp kind=%0d pc=%h", i, log_kind[base+i], log_pc[base+i], exp_kind[i], exp_pc[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (log_cyc[base+i] != log_cyc[base+i-1] + 1) begin errors++; $display("FAIL alt_gap[%0d] got=%0d exp=1", i, log_cyc[base+i] - log_cyc[base+i-1]); end
                end
            end
            checks++; if (log_tgt[base+2] !== 16'h2222 || log_taken[base+3] !== 1'b0) begin errors++; $display("FAIL alt_data got tgt=%h tk=%b exp 2222 0", log_tgt[base+2], log_taken[base+3]); end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int ti = 0;
        int bi = 0;
        base = log_kind.size();
        s_tpc.delete(); s_ttgt.delete(); s_bpc.delete(); s_btk.delete();
        for (int i = 0; i < 8; i++) begin
            s_tpc.push_back(16'h2000 + 16'(i)); s_ttgt.push_back(16'h3000 + 16'(i));
            s_bpc.push_back(16'h4000 + 16'(i)); s_btk.push_back(i[0]);
        end
        drive_streams();
        // Tag queue keeps the arbiter alternating, so BHT pops every other cycle and fills on the 6th accept
        checks++; if (bht_low_at != 6) begin errors++; $display("FAIL bht_full_at got=%0d exp=6", bht_low_at); end
        wait_writes(base + 16);
        checks++; if (log_kind.size() != base + 16) begin errors++; $display("FAIL b2b_count got=%0d exp=16", log_kind.size() - base); end
        for (int i = base; i < log_kind.size(); i++) begin
            if (log_kind[i] == 1) begin
                checks++;
                if (ti >= 8 || log_pc[i] !== 16'h2000 + 16'(ti) || log_tgt[i] !== 16'h3000 + 16'(ti)) begin errors++; $display("FAIL b2b_tag[%0d] got pc=%h tgt=%h", ti, log_pc[i], log_tgt[i]); end
                ti++;
            end else begin
                checks++;
                if (bi >= 8 || log_pc[i] !== 16'h4000 + 16'(bi) || log_taken[i] !== 1'(bi)) begin errors++; $display("FAIL b2b_bht[%0d] got pc=%h tk=%b", bi, log_pc[i], log_taken[i]); end
                bi++;
            end
        end
    endtask

    task automatic test_flush();
        int base;
        base = log_kind.size();
        @(negedge clk);
        tag_valid = 1'b1; tag_pc = 16'h5555; tag_target = 16'h6666;
        bht_valid = 1'b1; bht_pc = 16'h7777; bht_taken = 1'b1;
        @(negedge clk);
        tag_pc = 16'h1111; bht_pc = 16'h2222; flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0; tag_valid = 1'b0; bht_valid = 1'b0;
        checks++; if (tbl_tag_we !== 1'b0 || tbl_bht_we !== 1'b0) begin errors++; $display("FAIL flush_we got=%b%b exp=00", tbl_tag_we, tbl_bht_we); end
        checks++; if (busy !== 1'b1 || tag_ready !== 1'b0 || bht_ready !== 1'b0) begin errors++; $display("FAIL flush_busy got busy=%b rdy=%b%b exp 1 00", busy, tag_ready, bht_ready); end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            checks++;
            if (tbl_clr !== 1'b1 || tbl_idx !== 8'(i)) begin errors++; $display("FAIL flush_sweep got clr=%b idx=%h exp 1 %h", tbl_clr, tbl_idx, 8'(i)); end
        end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || tag_ready !== 1'b1 || bht_ready !== 1'b1) begin errors++; $display("FAIL flush_end got busy=%b rdy=%b%b exp 0 11", busy, tag_ready, bht_ready); end
        checks++; if (log_kind.size() != base) begin errors++; $display("FAIL flush_drop got=%0d exp=0 writes", log_kind.size() - base); end
    endtask

    task automatic test_coalesce();
        int base;
        int nt = 0;
        int nb = 0;
        logic [15:0] tp [$];
        logic [15:0] tt [$];
`ifdef BP_TAG_COALESCE_EN
        logic [15:0] ep [$] = '{16'h0011, 16'h0040};
        logic [15:0] et [$] = '{16'h0022, 16'h0060};
`else
        logic [15:0] ep [$] = '{16'h0011, 16'h0040, 16'h0040};
        logic [15:0] et [$] = '{16'h0022, 16'h0050, 16'h0060};
`endif
        bht_valid = 1'b1; bht_pc = 16'h0099; bht_taken = 1'b0;
        @(negedge clk);
        bht_valid = 1'b0;
        wait_writes(log_kind.size() + 1);
        base = log_kind.size();
        s_tpc = '{16'h0011, 16'h0040, 16'h0040}; s_ttgt = '{16'h0022, 16'h0050, 16'h0060};
        s_bpc = '{16'h0B01, 16'h0B02, 16'h0B03}; s_btk = '{1'b0, 1'b1, 1'b0};
        drive_streams();
        wait_writes(base + 3 + ep.size());
        for (int i = base; i < log_kind.size(); i++) begin
            if (log_kind[i] == 1) begin tp.push_back(log_pc[i]); tt.push_back(log_tgt[i]); nt++; end
            else nb++;
        end
        checks++; if (nt != ep.size() || nb != 3) begin errors++; $display("FAIL coal_count got tag=%0d bht=%0d exp tag=%0d bht=3", nt, nb, ep.size()); end
        else begin
            for (int i = 0; i < nt; i++) begin
                checks++;
                if (tp[i] !== ep[i] || tt[i] !== et[i]) begin errors++; $display("FAIL coal_tag[%0d] got pc=%h tgt=%h exp %h %h", i, tp[i], tt[i], ep[i], et[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        tag_valid = 1'b1; tag_pc = 16'h0AAA; tag_target = 16'h0BBB;
        bht_valid = 1'b1; bht_pc = 16'h0CCC; bht_taken = 1'b1;
        @(negedge clk);
        tag_pc = 16'h0DDD;
        @(negedge clk);
        tag_valid = 1'b0; bht_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || tag_ready !== 1'b0 || bht_ready !== 1'b0) begin errors++; $display("FAIL rmid_state got busy=%b rdy=%b%b exp 1 00", busy, tag_ready, bht_ready); end
        checks++; if ({tbl_clr, tbl_tag_we, tbl_bht_we} !== 3'b000 || tbl_idx !== 8'h00 || tbl_tag !== 8'h00) begin errors++; $display("FAIL rmid_out got we=%b idx=%h tag=%h exp 000 00 00", {tbl_clr, tbl_tag_we, tbl_bht_we}, tbl_idx, tbl_tag); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (tbl_clr !== 1'b1 || tbl_idx !== 8'h00 || tbl_tag_we !== 1'b0 || tbl_bht_we !== 1'b0) begin errors++; $display("FAIL rmid_clr0 got clr=%b idx=%h we=%b%b exp 1 00 00", tbl_clr, tbl_idx, tbl_tag_we, tbl_bht_we); end
        @(negedge clk);
        checks++; if (tbl_clr !== 1'b1 || tbl_idx !== 8'h01) begin errors++; $display("FAIL rmid_clr1 got clr=%b idx=%h exp 1 01", tbl_clr, tbl_idx); end
    endtask

    initial begin
        test_reset();
        test_single_tag();
        test_single_bht();
        test_alternate();
        test_back_to_back();
        test_flush();
        test_coalesce();
        checks++; if (onehot_err != 0) begin errors++; $display("FAIL onehot got=%0d exp=0 cycles", onehot_err); end
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
